// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath and its MAC sequencer.
// Holds the default N/Q/d constants, the sequencer state encoding and the
// address-width helper that sizes the x/weight index.
package neuron_pkg;

  localparam int N_DEFAULT = 16;  // datapath word width
  localparam int Q_DEFAULT = 8;   // fractional bits
  localparam int D_DEFAULT = 4;   // input/weight pairs per neuron

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_MAC,
    ST_RES,
    ST_DONE
  } seq_state_t;

  // Index width for d pairs; a single pair still needs a 1-bit address.
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_index_counter.sv
// x/weight pair index counter for the MAC sequencer.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear to 0 (has priority over inc)
//   inc       - advance by one; saturates at D-1 so the index never wraps
//   idx       - current pair index
//   tc        - terminal count, high while idx == D-1
module mac_index_counter
  import neuron_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int AW = addr_width(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] idx,
  output logic          tc
);

  localparam logic [AW-1:0] LAST = AW'(D - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !tc) begin
      idx <= idx + AW'(1);
    end
  end

  assign tc = (idx == LAST);

endmodule

// File: rtl/mac_sequencer.sv
// Control FSM for one neuron evaluation: clear the accumulator, then for each
// of d x/weight pairs load both registers and accumulate their product, then
// capture the activation result and pulse done.
//
//   state | meaning
//   IDLE  | waiting for st; index held at 0
//   CLEAR | one-cycle accumulator clear
//   LOAD  | load x/weight at addr when mem_rdy (stalls otherwise)
//   MAC   | one-cycle accumulate; advance addr or finish
//   RES   | write result when ready (stalls otherwise)
//   DONE  | one-cycle completion pulse
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   st                  - start request, only looked at in IDLE
//   mem_rdy             - memories present valid data at addr
//   ready               - datapath activation output valid
//   addr                - current x/weight pair index
//   clear_acc, x_write, w_write, acc_en, res_write - datapath strobes
//   busy                - any state other than IDLE
//   done                - one-cycle completion pulse
module mac_sequencer
  import neuron_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int Q = Q_DEFAULT,
  parameter int d = D_DEFAULT,
  localparam int AW = addr_width(d)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          mem_rdy,
  input  logic          ready,
  output logic [AW-1:0] addr,
  output logic          clear_acc,
  output logic          x_write,
  output logic          w_write,
  output logic          acc_en,
  output logic          res_write,
  output logic          busy,
  output logic          done
);

  // N and Q only size the datapath; an out-of-range configuration gets an
  // empty marker block so it is visible in the elaborated hierarchy.
  if (d < 1 || d > 256 || Q >= N) begin : g_cfg_out_of_range
  end

  seq_state_t state;
  logic       last_pair;
  logic       cnt_clr;
  logic       cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (st) state <= ST_CLEAR;
        ST_CLEAR: state <= ST_LOAD;
        ST_LOAD:  if (mem_rdy) state <= ST_MAC;
        ST_MAC:   state <= last_pair ? ST_RES : ST_LOAD;
        ST_RES:   if (ready) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Index returns to 0 on the way out of MAC so RES/DONE/IDLE all see 0.
  assign cnt_clr = (state == ST_IDLE) || (state == ST_CLEAR) ||
                   ((state == ST_MAC) && last_pair);
  assign cnt_inc = (state == ST_MAC) && !last_pair;

  mac_index_counter #(
    .D  (d),
    .AW (AW)
  ) u_index (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .idx (addr),
    .tc  (last_pair)
  );

  // Strobes decode from the state register; only the LOAD and RES strobes
  // look at their handshake input, so each fires once per accepted transfer.
  assign clear_acc = (state == ST_CLEAR);
  assign x_write   = (state == ST_LOAD) && mem_rdy;
  assign w_write   = (state == ST_LOAD) && mem_rdy;
  assign acc_en    = (state == ST_MAC);
  assign res_write = (state == ST_RES) && ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic mem_rdy, ready;
  logic st4, st1;

  logic [1:0] addr4;
  logic       clr4, xw4, ww4, acc4, res4, busy4, done4;
  logic [0:0] addr1;
  logic       clr1, xw1, ww1, acc1, res1, busy1, done1;

  always #5 clk = ~clk;

  mac_sequencer #(.N(16), .Q(8), .d(4)) dut4 (
    .clk(clk), .rst(rst), .st(st4), .mem_rdy(mem_rdy), .ready(ready),
    .addr(addr4), .clear_acc(clr4), .x_write(xw4), .w_write(ww4),
    .acc_en(acc4), .res_write(res4), .busy(busy4), .done(done4)
  );

  mac_sequencer #(.N(16), .Q(8), .d(1)) dut1 (
    .clk(clk), .rst(rst), .st(st1), .mem_rdy(mem_rdy), .ready(ready),
    .addr(addr1), .clear_acc(clr1), .x_write(xw1), .w_write(ww1),
    .acc_en(acc1), .res_write(res1), .busy(busy1), .done(done1)
  );

  // event bits: [0] clear_acc [1] load [2] acc_en [3] res_write [4] done
  typedef struct {
    logic [4:0] ev;
    int         a;
    int         cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   done_cycs4[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt4 = 0, res_cnt4 = 0, acc_cnt1 = 0, load_cnt1 = 0;
  int   last_done1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected event stream for one evaluation started with st sampled at the
  // end of cycle base.
  task automatic push_eval(input int dd, input int base, input int stall_idx,
                           input int stall_n, input int rdy_stall, input bit one);
    exp_t e[$];
    int t;
    e.push_back('{ev: 5'b00001, a: 0, cyc: base + 1});
    t = base + 2;
    for (int i = 0; i < dd; i++) begin
      if (i == stall_idx) t += stall_n;
      e.push_back('{ev: 5'b00010, a: i, cyc: t});
      t++;
      e.push_back('{ev: 5'b00100, a: i, cyc: t});
      t++;
    end
    t += rdy_stall;
    e.push_back('{ev: 5'b01000, a: 0, cyc: t});
    t++;
    e.push_back('{ev: 5'b10000, a: 0, cyc: t});
    foreach (e[k]) begin
      if (one) q1.push_back(e[k]);
      else     q4.push_back(e[k]);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a strobe or done.
  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t x;
    if (rst) begin
      ev = {done4, res4, acc4, xw4, clr4};
      if (ev != 5'b0) begin
        if (acc4) acc_cnt4++;
        if (res4) res_cnt4++;
        if (done4) done_cycs4.push_back(cyc);
        if (ev[3:0] != 4'b0) check("d4_mutex", $countones(ev[3:0]), 1);
        if (xw4) check("d4_w_write", int'(ww4), 1);
        if (q4.size() == 0) begin
          check("d4_unexpected_event", int'(ev), 0);
        end else begin
          x = q4.pop_front();
          check("d4_event", int'(ev), int'(x.ev));
          check("d4_addr", int'(addr4), x.a);
          check("d4_cycle", cyc, x.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] ev;
    exp_t x;
    if (rst) begin
      ev = {done1, res1, acc1, xw1, clr1};
      if (ev != 5'b0) begin
        if (acc1) acc_cnt1++;
        if (xw1) load_cnt1++;
        if (done1) last_done1 = cyc;
        if (q1.size() == 0) begin
          check("d1_unexpected_event", int'(ev), 0);
        end else begin
          x = q1.pop_front();
          check("d1_event", int'(ev), int'(x.ev));
          check("d1_addr", int'(addr1), x.a);
          check("d1_cycle", cyc, x.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic start4(output int base);
    st4 = 1'b1;
    base = cyc;
    step();
    st4 = 1'b0;
  endtask

  int b;

  initial begin
    rst = 1'b0;
    mem_rdy = 1'b1;
    ready = 1'b1;
    st4 = 1'b0;
    st1 = 1'b0;
    #12;
    check("reset_busy", int'(busy4), 0);
    check("reset_addr", int'(addr4), 0);
    check("reset_done", int'(done4), 0);
    rst = 1'b1;
    step();

    // nominal d=4 evaluation
    acc_cnt4 = 0; done_cycs4.delete();
    start4(b);
    push_eval(4, b, -1, 0, 0, 1'b0);
    @(negedge clk); check("t1_busy_c1", int'(busy4), 1);
    wait_until(b + 11); @(negedge clk); check("t1_busy_c11", int'(busy4), 1);
    wait_until(b + 12); @(negedge clk); check("t1_busy_c12", int'(busy4), 0);
    check("t1_done_cycle", done_cycs4.size() > 0 ? done_cycs4[0] - b : -1, 11);
    check("t1_acc_count", acc_cnt4, 4);
    wait_until(b + 14);

    // mem_rdy stall at addr 2, plus an st pulse mid-evaluation that is ignored
    acc_cnt4 = 0; done_cycs4.delete();
    start4(b);
    push_eval(4, b, 2, 3, 0, 1'b0);
    wait_until(b + 5); st4 = 1'b1;
    wait_until(b + 6); st4 = 1'b0; mem_rdy = 1'b0;
    wait_until(b + 9); mem_rdy = 1'b1;
    wait_until(b + 17);
    check("t2_done_cycle", done_cycs4.size() > 0 ? done_cycs4[0] - b : -1, 14);
    check("t2_acc_count", acc_cnt4, 4);

    // ready stall in RES
    res_cnt4 = 0; done_cycs4.delete();
    start4(b);
    push_eval(4, b, -1, 0, 5, 1'b0);
    wait_until(b + 10); ready = 1'b0;
    wait_until(b + 15); ready = 1'b1;
    wait_until(b + 19);
    check("t3_done_cycle", done_cycs4.size() > 0 ? done_cycs4[0] - b : -1, 16);
    check("t3_res_count", res_cnt4, 1);

    // st held high for 30 cycles: back-to-back evaluations
    done_cycs4.delete();
    st4 = 1'b1;
    b = cyc;
    push_eval(4, b, -1, 0, 0, 1'b0);
    push_eval(4, b + 12, -1, 0, 0, 1'b0);
    push_eval(4, b + 24, -1, 0, 0, 1'b0);
    wait_until(b + 30); st4 = 1'b0;
    wait_until(b + 40);
    check("t4_done_count", done_cycs4.size(), 3);
    check("t4_done1", done_cycs4.size() > 0 ? done_cycs4[0] - b : -1, 11);
    check("t4_done2", done_cycs4.size() > 1 ? done_cycs4[1] - b : -1, 23);
    check("t4_done3", done_cycs4.size() > 2 ? done_cycs4[2] - b : -1, 35);

    // asynchronous reset in MAC at addr 2
    start4(b);
    push_eval(4, b, -1, 0, 0, 1'b0);
    wait_until(b + 7);
    @(negedge clk); #1;
    check("t5_pre_addr", int'(addr4), 2);
    rst = 1'b0;
    q4.delete();
    #1;
    check("t5_rst_addr", int'(addr4), 0);
    check("t5_rst_strobes", int'({clr4, xw4, ww4, acc4, res4}), 0);
    check("t5_rst_busy", int'(busy4), 0);
    check("t5_rst_done", int'(done4), 0);
    #1;
    rst = 1'b1;
    step();
    acc_cnt4 = 0; done_cycs4.delete();
    start4(b);
    push_eval(4, b, -1, 0, 0, 1'b0);
    wait_until(b + 13);
    check("t5_acc_count", acc_cnt4, 4);
    check("t5_done_cycle", done_cycs4.size() > 0 ? done_cycs4[0] - b : -1, 11);

    // d=1 instance
    acc_cnt1 = 0; load_cnt1 = 0; last_done1 = 0;
    st1 = 1'b1;
    b = cyc;
    step();
    st1 = 1'b0;
    push_eval(1, b, -1, 0, 0, 1'b1);
    wait_until(b + 8);
    check("t6_done_cycle", last_done1 - b, 5);
    check("t6_acc_count", acc_cnt1, 1);
    check("t6_load_count", load_cnt1, 1);

    wait_until(cyc + 5);
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter N, default 16, datapath word width in bits; passed through for package sizing only.
REQ-002 Parameter Q, default 8, fractional bits of the datapath fixed-point format; no effect on sequencing.
REQ-003 Parameter d, default 4, number of input/weight pairs per neuron evaluation; legal range 1..256.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 st  input  1  start request; sampled only in IDLE.
REQ-007 mem_rdy  input  1  input/weight memories present valid data at addr this cycle.
REQ-008 ready  input  1  datapath result (activation output) valid.
REQ-009 addr  output  AW=max(1,clog2(d))  index of the current x/weight pair.
REQ-010 clear_acc  output  1  clear datapath accumulator.
REQ-011 x_write  output  1  load x register from memory.
REQ-012 w_write  output  1  load weight register from memory.
REQ-013 acc_en  output  1  accumulate x*weight product.
REQ-014 res_write  output  1  write datapath result to output register.
REQ-015 busy  output  1  evaluation in progress (any state other than IDLE).
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, LOAD, MAC, RES, DONE; all outputs are Moore-decoded from state and addr except res_write and the LOAD strobes, which are additionally qualified as stated below.
REQ-018 IDLE: st=1 -> CLEAR; st=0 -> stay; addr held at 0.
REQ-019 CLEAR: clear_acc=1 for exactly one cycle; addr reset to 0; -> LOAD.
REQ-020 LOAD: x_write=w_write=mem_rdy; mem_rdy=1 -> MAC; mem_rdy=0 -> stay in LOAD with no strobes (stall, no timeout).
REQ-021 MAC: acc_en=1 for exactly one cycle; if addr==d-1 -> RES with addr cleared to 0, else addr increments by 1 and -> LOAD.
REQ-022 RES: res_write=ready; ready=1 -> DONE; ready=0 -> stay (stall, no timeout).
REQ-023 DONE: done=1 for exactly one cycle; -> IDLE unconditionally; st in DONE is ignored.
REQ-024 st asserted in any state other than IDLE SHALL be ignored; no queuing of requests.
REQ-025 clear_acc, acc_en, x_write/w_write, res_write SHALL be mutually exclusive in every cycle.
REQ-026 Latency with mem_rdy=ready=1: st sampled at edge 0 -> CLEAR cycle 1, LOAD/MAC cycles 2..2d+1, RES cycle 2d+2, done high in cycle 2d+3; total 2d+3 cycles.
REQ-027 d=1: exactly one LOAD/MAC pair, addr never leaves 0.
REQ-028 addr SHALL never exceed d-1; no wrap-around inside an evaluation.
REQ-029 Exactly d acc_en pulses and exactly one clear_acc and one res_write pulse occur per evaluation regardless of stalls.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, addr=0, and all strobes, busy and done to 0, including mid-evaluation.
REQ-031 After rst release, the first st is accepted on the first rising edge at which the block is in IDLE; no partial evaluation resumes.

Structure
REQ-032 A shared package neuron_pkg SHALL hold the state enumeration, the AW width function, and the default N/Q/d constants used by the datapath and this block.
REQ-033 One sub-module, mac_index_counter (clear, increment, terminal-count flag at d-1), SHALL implement addr; the FSM stays in mac_sequencer.

Verification
REQ-034 d=4, mem_rdy=ready=1, st pulse at edge 0 -> clear_acc cycle 1, acc_en cycles 3,5,7,9 with addr 0,1,2,3, res_write cycle 10, done cycle 11, busy cycles 1..11.
REQ-035 d=4, mem_rdy low for 3 cycles in the LOAD at addr=2 -> x_write/w_write absent during stall, acc_en count still 4, done delayed by 3 cycles (cycle 14).
REQ-036 d=4, ready held low 5 cycles in RES -> res_write and done both delayed 5 cycles, res_write single pulse coincident with ready=1.
REQ-037 st held high continuously for 30 cycles, d=4 -> back-to-back evaluations, done at cycles 11 and 23, no st acceptance in DONE.
REQ-038 rst=0 asserted asynchronously in MAC at addr=2 -> outputs 0 and addr 0 immediately; after release with st=1 a full fresh evaluation with 4 acc_en pulses.
REQ-039 d=1, single st -> one x_write, one acc_en at addr 0, done in cycle 5.
